// File: rtl/rgb_frame_writer_pkg.sv
// Shared definitions for the RGB pipeline: frame-writer FSM states and the
// slot order of channels inside a packed {r,g,b} pixel word.
package rgb_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Channel slot index within a packed pixel; slot 2 occupies the MSBs.
    localparam int unsigned SLOT_R = 2;
    localparam int unsigned SLOT_G = 1;
    localparam int unsigned SLOT_B = 0;

endpackage

// File: rtl/rgb_frame_writer_pixel_counter.sv
// Row-major pixel position counter: col wraps into row, addr tracks row*COLS+col.
module pixel_counter #(
    parameter int ROWS      = 5,
    parameter int COLS      = 6,
    parameter int ADDR_BITS = 10,
    localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [COL_BITS-1:0]  col,
    output logic [ROW_BITS-1:0]  row,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last
);

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ROW_BITS'(1);
            end else begin
                col <= col + COL_BITS'(1);
            end
            addr <= last ? '0 : addr + ADDR_BITS'(1);
        end
    end

endmodule

// File: rtl/rgb_frame_writer.sv
// Captures one ROWS x COLS frame of filtered RGB pixels after a start pulse and
// writes each packed pixel to the frame buffer one cycle after it is accepted.
module rgb_frame_writer
    import rgb_frame_writer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 5,
    parameter int COLS      = 6,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     r_data_in,
    input  logic [WIDTH-1:0]     g_data_in,
    input  logic [WIDTH-1:0]     b_data_in,
    input  logic                 data_in_done,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [3*WIDTH-1:0]   mem_wdata,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 dropped
);

    localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t state, state_next;

    logic                 accept;
    logic                 arm;
    logic                 last;
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic [ADDR_BITS-1:0] addr;

    assign accept = (state == ACTIVE) && data_in_done;
    assign arm    = (state == IDLE) && start;

    pixel_counter #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .ADDR_BITS (ADDR_BITS)
    ) u_pixel_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (arm),
        .inc   (accept),
        .col   (col),
        .row   (row),
        .addr  (addr),
        .last  (last)
    );

    // Position is carried by addr; col/row are only needed inside the counter.
    logic unused_pos;
    assign unused_pos = ^{col, row};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (accept && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Stray pixels outside ACTIVE win over the clear from an arming start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dropped   <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr                             <= addr;
                mem_wdata[SLOT_R*WIDTH +: WIDTH]     <= r_data_in;
                mem_wdata[SLOT_G*WIDTH +: WIDTH]     <= g_data_in;
                mem_wdata[SLOT_B*WIDTH +: WIDTH]     <= b_data_in;
            end
            dropped <= (dropped && !arm) || (data_in_done && (state != ACTIVE));
        end
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Randomized bench for rgb_frame_writer against a pixel-count reference model.
module tb_rgb_frame_writer;

    localparam int WIDTH     = 8;
    localparam int ROWS      = 5;
    localparam int COLS      = 6;
    localparam int ADDR_BITS = 10;
    localparam int NPIX      = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     r_data_in, g_data_in, b_data_in;
    logic                 data_in_done;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [3*WIDTH-1:0]   mem_wdata;
    logic                 busy, frame_done, dropped;

    rgb_frame_writer #(
        .WIDTH     (WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .r_data_in    (r_data_in),
        .g_data_in    (g_data_in),
        .b_data_in    (b_data_in),
        .data_in_done (data_in_done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .frame_done   (frame_done),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is "open" from an arming start until NPIX
    // pixels have been taken; the cycle after the last one is the done cycle.
    bit        m_open, m_done, m_dropped;
    int        m_n;
    bit        exp_we;
    int        exp_addr;
    logic [23:0] exp_wdata;
    int        writes, done_pulses;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit st, input bit dv, input logic [23:0] px);
        bit idle, acc;
        start        = st;
        data_in_done = dv;
        {r_data_in, g_data_in, b_data_in} = px;
        @(posedge clk);
        idle = !m_open && !m_done;
        acc  = m_open && dv;
        if (dv && !m_open)     m_dropped = 1'b1;
        else if (st && idle)   m_dropped = 1'b0;
        exp_we = acc;
        if (acc) begin
            exp_addr  = m_n;
            exp_wdata = px;
        end
        m_done = 1'b0;
        if (st && idle) begin
            m_open = 1'b1;
            m_n    = 0;
        end
        if (acc) begin
            m_n++;
            if (m_n == NPIX) begin
                m_open = 1'b0;
                m_done = 1'b1;
            end
        end
        #1;
        check_eq("mem_we", mem_we, exp_we);
        check_eq("frame_done", frame_done, m_done);
        check_eq("busy", busy, m_open || m_done);
        check_eq("dropped", dropped, m_dropped);
        if (exp_we) begin
            check_eq("mem_addr", mem_addr, exp_addr);
            check_eq("mem_wdata", mem_wdata, exp_wdata);
        end
        if (mem_we)     writes++;
        if (frame_done) done_pulses++;
        start        = 1'b0;
        data_in_done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_we"},    mem_we, 0);
        check_eq({tag, "_addr"},  mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_done"},  frame_done, 0);
        check_eq({tag, "_drop"},  dropped, 0);
    endtask

    task automatic model_clear();
        m_open = 0; m_done = 0; m_dropped = 0; m_n = 0; exp_we = 0;
    endtask

    task automatic frame_stats(input string tag);
        check_eq({tag, "_writes"}, writes, NPIX);
        check_eq({tag, "_pulses"}, done_pulses, 1);
        writes = 0;
        done_pulses = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in_done = 1'b0;
        r_data_in = '0; g_data_in = '0; b_data_in = '0;
        model_clear();
        writes = 0; done_pulses = 0;
        #1 check_reset_state("por");
        @(posedge clk); #1 reset = 1'b0;

        // Unarmed pixel, then a start clears the sticky flag.
        cycle(0, 1, 24'($urandom));
        cycle(0, 0, 24'h0);
        cycle(1, 0, 24'h0);

        // Back-to-back full frame; pixel 6 is the first of row 1.
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, (i == 6) ? 24'hAA550F : 24'($urandom));
            if (i == 6) begin
                check_eq("wrap_addr", mem_addr, 6);
                check_eq("wrap_wdata", mem_wdata, 24'hAA550F);
            end
        end
        cycle(0, 1, 24'($urandom));     // 31st pixel lands in the done cycle
        cycle(0, 0, 24'h0);
        frame_stats("b2b");

        // Sparse frame with random gaps and stray start pulses while active.
        cycle(1, 0, 24'h0);
        for (int i = 0; i < NPIX; i++) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            for (int k = 0; k < gap; k++) cycle(bit'($urandom_range(0, 1)), 0, 24'h0);
            cycle(bit'($urandom_range(0, 1)), 1, 24'($urandom));
        end
        for (int k = 0; k < 3; k++) cycle(0, 0, 24'h0);
        frame_stats("sparse");

        // Start and pixel together in idle arms but drops the pixel; reset mid-frame.
        cycle(1, 1, 24'($urandom));
        for (int i = 0; i < 12; i++) cycle(0, 1, 24'($urandom));
        reset = 1'b1;
        #1 check_reset_state("midrst");
        model_clear();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        writes = 0; done_pulses = 0;
        for (int k = 0; k < 3; k++) cycle(0, 0, 24'h0);
        check_eq("post_rst_writes", writes, 0);
        cycle(1, 0, 24'h0);
        for (int i = 0; i < NPIX; i++) cycle(0, 1, 24'($urandom));
        cycle(0, 0, 24'h0);
        frame_stats("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_frame_writer.md
RGB_FRAME_WRITER -- requirements
Module: rgb_frame_writer

Interface
REQ-001 Parameter WIDTH, 8, bits per colour channel.
REQ-002 Parameter ROWS, 5, frame height in pixels.
REQ-003 Parameter COLS, 6, frame width in pixels.
REQ-004 Parameter ADDR_BITS, 10, frame-buffer address width; ROWS*COLS SHALL NOT exceed 2**ADDR_BITS.
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that arms capture of one frame.
REQ-008 r_data_in / g_data_in / b_data_in  input  WIDTH each  filtered pixel channels from the filter stage.
REQ-009 data_in_done  input  1  pixel-valid strobe; channels are valid in any cycle it is high.
REQ-010 mem_we  output  1  frame-buffer write enable.
REQ-011 mem_addr  output  ADDR_BITS  frame-buffer write address.
REQ-012 mem_wdata  output  3*WIDTH  packed pixel {r,g,b}, r in the MSBs.
REQ-013 busy  output  1  high in ACTIVE and DONE.
REQ-014 frame_done  output  1  one-cycle pulse on completion of the frame.
REQ-015 dropped  output  1  sticky flag: a pixel arrived while not armed.

Function
REQ-016 FSM states: IDLE, ACTIVE, DONE.
REQ-017 Transitions:
- IDLE->ACTIVE on start.
- ACTIVE->DONE on acceptance of pixel ROWS*COLS.
- DONE->IDLE unconditionally after one cycle.
REQ-018 A pixel SHALL be accepted only when state is ACTIVE and data_in_done=1.
REQ-019 Write latency: each accepted pixel SHALL produce mem_we=1 exactly one cycle later, with registered mem_addr and mem_wdata.
REQ-020 mem_we SHALL be 0 in every cycle that does not follow an acceptance.
REQ-021 Write addressing:
- The first write after start SHALL use mem_addr=0.
- Each following write SHALL use the previous address +1 (row-major: row*COLS+col).
REQ-022 Internal col counter:
- Counts 0..COLS-1 and wraps to 0 after COLS-1.
- Each wrap SHALL increment the row counter, range 0..ROWS-1.
REQ-023 Acceptance at row=ROWS-1, col=COLS-1 SHALL move the FSM to DONE.
REQ-024 frame_done SHALL be 1 for exactly the DONE cycle, which is the same cycle as the last mem_we.
REQ-025 On entry to ACTIVE, the counters and address SHALL be cleared.
REQ-026 start while ACTIVE or DONE SHALL be ignored.
REQ-027 start and data_in_done high together in IDLE: the pixel is not accepted and dropped SHALL be set.
REQ-028 Any data_in_done in IDLE or DONE SHALL set dropped, with no write and no counter change.
REQ-029 dropped SHALL be cleared only by reset or by start accepted in IDLE.
REQ-030 Back-to-back data_in_done every cycle SHALL be accepted without loss.
REQ-031 Gaps of any length between pixels SHALL be tolerated.

Reset
REQ-032 Asserting reset SHALL asynchronously force:
- state=IDLE
- counters=0
- mem_we=0, mem_addr=0, mem_wdata=0
- busy=0, frame_done=0, dropped=0
REQ-033 Reset mid-frame SHALL abandon the frame, and no further writes SHALL occur until the next start after reset release.

Structure
REQ-034 The FSM state encoding and the {r,g,b} packing order SHALL live in a shared package used by all pipeline stages.
REQ-035 The row/col/address counter SHALL be a separate sub-module, pixel_counter (parameters ROWS, COLS, ADDR_BITS; inputs clr, inc; outputs col, row, addr, last).
REQ-036 No other sub-modules.

Verification
REQ-037 Full frame: start, then 30 pixels on consecutive cycles -> 30 writes to addresses 0..29, with frame_done high on the cycle of the addr=29 write and busy low one cycle later.
REQ-038 Row wrap: pixel 6 with r=8'hAA, g=8'h55, b=8'h0F -> mem_addr=6, mem_wdata=24'hAA550F, one cycle after its data_in_done.
REQ-039 Unarmed pixel: data_in_done before any start -> no mem_we and dropped=1; a subsequent start clears dropped.
REQ-040 Sparse input: 30 pixels with random 0-5 cycle gaps -> addresses 0..29 in order, and exactly one frame_done pulse.
REQ-041 Reset mid-frame: reset asserted after 12 pixels -> mem_we=0 immediately; the next start plus 30 pixels writes from addr 0.
REQ-042 Extra input: a 31st pixel presented in the DONE cycle -> no write and dropped=1; start pulsed during ACTIVE -> no effect on the address sequence.
